// File: rtl/segment7_scan.sv
// Time-multiplexed common-anode 7-segment driver: shadowed display word, programmable
// refresh rate, hex decode, leading-zero blanking and per-digit blinking.
module segment7_scan #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int HEX_EN       = 1,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [4*DIGITS-1:0] digits_in,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                blank_lz,
    input  logic [DIGITS-1:0]   blink_mask,
    output logic [6:0]          seg,
    output logic                dp_n,
    output logic [DIGITS-1:0]   an,
    output logic                frame_tick
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [4*DIGITS-1:0] sh_dig_reg;
    logic [DIGITS-1:0]   sh_dp_reg;
    logic [RW-1:0]       rcnt_reg, rcnt_next;
    logic [IW-1:0]       idx_reg, idx_next;
    logic [FW-1:0]       fcnt_reg, fcnt_next;
    logic                phase_reg, phase_next;
    logic                frame_tick_reg, frame_tick_next;
    logic [6:0]          seg_reg, seg_next;
    logic                dp_n_reg, dp_n_next;
    logic [DIGITS-1:0]   an_reg, an_next;

    logic                rcnt_tc;
    logic                idx_last;
    logic                fcnt_last;
    logic [3:0]          nib [DIGITS];
    logic [DIGITS:0]     upper_zero;
    logic [DIGITS-1:0]   lz_blank;
    logic [3:0]          cur_nib;

    assign rcnt_tc   = (rcnt_reg == RW'(REFRESH_DIV - 1));
    assign idx_last  = (idx_reg == IW'(DIGITS - 1));
    assign fcnt_last = (fcnt_reg == FW'(BLINK_FRAMES - 1));

    // upper_zero[i]: nibbles DIGITS-1..i are all zero
    assign upper_zero[DIGITS] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib[gi]        = sh_dig_reg[4*gi +: 4];
            assign upper_zero[gi] = (nib[gi] == 4'd0) && upper_zero[gi+1];
            if (gi == 0) begin : g_lsd
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = blank_lz && upper_zero[gi];
            end
        end
    endgenerate

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        s = 7'b1111111;
        case (code)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = (HEX_EN != 0) ? 7'b0001000 : 7'b1111111;
            4'hB: s = (HEX_EN != 0) ? 7'b1100000 : 7'b1111111;
            4'hC: s = (HEX_EN != 0) ? 7'b0110001 : 7'b1111111;
            4'hD: s = (HEX_EN != 0) ? 7'b1000010 : 7'b1111111;
            4'hE: s = (HEX_EN != 0) ? 7'b0110000 : 7'b1111111;
            4'hF: s = (HEX_EN != 0) ? 7'b0111000 : 7'b1111111;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Scan timing: refresh counter, digit index, frame tick and blink phase.
    // The blink frame counter advances on the same wrap that raises frame_tick.
    always_comb begin
        rcnt_next       = rcnt_reg;
        idx_next        = idx_reg;
        fcnt_next       = fcnt_reg;
        phase_next      = phase_reg;
        frame_tick_next = 1'b0;
        if (rcnt_tc) begin
            rcnt_next = '0;
            if (idx_last) begin
                idx_next        = '0;
                frame_tick_next = 1'b1;
                if (fcnt_last) begin
                    fcnt_next  = '0;
                    phase_next = ~phase_reg;
                end else begin
                    fcnt_next = fcnt_reg + FW'(1);
                end
            end else begin
                idx_next = idx_reg + IW'(1);
            end
        end else begin
            rcnt_next = rcnt_reg + RW'(1);
        end
    end

    // Output decode from the current (pre-edge) index and shadow contents.
    always_comb begin
        cur_nib   = nib[idx_reg];
        seg_next  = decode(cur_nib);
        dp_n_next = ~sh_dp_reg[idx_reg];
        an_next   = ~(DIGITS'(1) << idx_reg);
        if (lz_blank[idx_reg]) begin
            seg_next = 7'b1111111;
        end
        if (blink_mask[idx_reg] && !phase_reg) begin
            seg_next  = 7'b1111111;
            dp_n_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_dig_reg     <= '0;
            sh_dp_reg      <= '0;
            rcnt_reg       <= '0;
            idx_reg        <= '0;
            fcnt_reg       <= '0;
            phase_reg      <= 1'b1;
            frame_tick_reg <= 1'b0;
            seg_reg        <= 7'b1111111;
            dp_n_reg       <= 1'b1;
            an_reg         <= '1;
        end else begin
            if (load) begin
                sh_dig_reg <= digits_in;
                sh_dp_reg  <= dp_in;
            end
            rcnt_reg       <= rcnt_next;
            idx_reg        <= idx_next;
            fcnt_reg       <= fcnt_next;
            phase_reg      <= phase_next;
            frame_tick_reg <= frame_tick_next;
            seg_reg        <= seg_next;
            dp_n_reg       <= dp_n_next;
            an_reg         <= an_next;
        end
    end

    assign seg        = seg_reg;
    assign dp_n       = dp_n_reg;
    assign an         = an_reg;
    assign frame_tick = frame_tick_reg;

endmodule
